// File: rtl/rot_pkg.sv
// Constants and types shared by the rotation stage and the pixel-fetch stage.
package rot_pkg;

  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;
  localparam int CX       = 400;
  localparam int CY       = 300;
  localparam int ROT_LAT  = 12;

  // Binary angle: 2^32 is one full turn
  localparam logic [31:0] ANG_45 = 32'h2000_0000;
  localparam logic [31:0] ANG_90 = 32'h4000_0000;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } vid_sync_t;

  localparam vid_sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b1};

  function automatic int total_latency(input int rot_lat, input int ram_lat);
    return rot_lat + 2 + ram_lat + 1;
  endfunction

endpackage

// File: rtl/rot_pixel_fetch_if.sv
// Bundle of video timing, rotation coordinates, sprite BRAM port and final pixel
// seen by the pixel-fetch stage.
interface rot_pixel_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int PIX_W  = 8
);
  logic [31:0]       angle_in;
  logic [31:0]       angle_out;
  logic [10:0]       hcount;
  logic [9:0]        vcount;
  logic              hsync;
  logic              vsync;
  logic              blank;
  logic [11:0]       x_rot;
  logic [10:0]       y_rot;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_data;
  logic [PIX_W-1:0]  pixel;
  logic              hsync_out;
  logic              vsync_out;
  logic              blank_out;

  modport master (
    input  angle_in, hcount, vcount, hsync, vsync, blank, x_rot, y_rot, mem_data,
    output angle_out, mem_addr, pixel, hsync_out, vsync_out, blank_out
  );

  modport slave (
    output angle_in, hcount, vcount, hsync, vsync, blank, x_rot, y_rot, mem_data,
    input  angle_out, mem_addr, pixel, hsync_out, vsync_out, blank_out
  );

endinterface

// File: rtl/rot_pixel_fetch_delay_line.sv
// Fixed-depth shift register with async active-low reset to a per-bit idle value.
module delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VAL;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/rot_pixel_fetch.sv
// Maps rotated screen coordinates to sprite BRAM reads, realigns VGA syncs with the
// returned pixel and latches the per-frame rotation angle on the vsync falling edge.
module rot_pixel_fetch #(
  parameter int              ROT_LAT  = rot_pkg::ROT_LAT,
  parameter int              RAM_LAT  = 2,
  parameter int              IMG_X0   = 272,
  parameter int              IMG_Y0   = 172,
  parameter int              IMG_W    = 256,
  parameter int              IMG_H    = 256,
  parameter int              ADDR_W   = 16,
  parameter int              PIX_W    = 8,
  parameter logic [PIX_W-1:0] BG_COLOR = '0
) (
  input logic                clk,
  input logic                reset,
  rot_pixel_fetch_if.master  bus
);
  import rot_pkg::*;

  localparam int TOTAL = total_latency(ROT_LAT, RAM_LAT);

  logic              vsync_q;
  logic signed [13:0] dx, dy, dx_q, dy_q;
  logic              in_b, in_q;
  logic              v2, vd;
  vid_sync_t         sync_in, sync_d;

  // Angle only changes on the vsync falling edge so a whole frame shares one angle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_q       <= 1'b1;
      bus.angle_out <= '0;
    end else begin
      vsync_q <= bus.vsync;
      if (vsync_q && !bus.vsync) bus.angle_out <= bus.angle_in;
    end
  end

  assign dx   = $signed({{2{bus.x_rot[11]}}, bus.x_rot}) - 14'(IMG_X0);
  assign dy   = $signed({{3{bus.y_rot[10]}}, bus.y_rot}) - 14'(IMG_Y0);
  assign in_b = !dx[13] && (dx < 14'(IMG_W)) && !dy[13] && (dy < 14'(IMG_H));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dx_q <= '0;
      dy_q <= '0;
      in_q <= 1'b0;
    end else begin
      dx_q <= dx;
      dy_q <= dy;
      in_q <= in_b;
    end
  end

  // Out-of-sprite pixels keep the previous address so no aliased location is read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mem_addr <= '0;
      v2           <= 1'b0;
    end else begin
      if (in_q) bus.mem_addr <= ADDR_W'(int'(dy_q) * IMG_W + int'(dx_q));
      v2 <= in_q;
    end
  end

  delay_line #(.WIDTH(1), .DEPTH(RAM_LAT), .RESET_VAL(1'b0)) u_valid_dly (
    .clk  (clk),
    .reset(reset),
    .din  (v2),
    .dout (vd)
  );

  assign sync_in = '{hsync: bus.hsync, vsync: bus.vsync, blank: bus.blank};

  // One stage short of TOTAL: the output register below supplies the last cycle
  delay_line #(.WIDTH($bits(vid_sync_t)), .DEPTH(TOTAL-1), .RESET_VAL(SYNC_IDLE)) u_sync_dly (
    .clk  (clk),
    .reset(reset),
    .din  (sync_in),
    .dout (sync_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.pixel     <= '0;
      bus.hsync_out <= 1'b1;
      bus.vsync_out <= 1'b1;
      bus.blank_out <= 1'b1;
    end else begin
      bus.hsync_out <= sync_d.hsync;
      bus.vsync_out <= sync_d.vsync;
      bus.blank_out <= sync_d.blank;
      if (sync_d.blank)  bus.pixel <= '0;
      else if (vd)       bus.pixel <= bus.mem_data;
      else               bus.pixel <= BG_COLOR;
    end
  end

endmodule

// File: tb/tb_rot_pixel_fetch.sv
// Self-checking bench for rot_pixel_fetch: vector table, hand-written latency/angle/reset
// sequences, then a randomized run scored against a cycle-history reference model.
module tb_rot_pixel_fetch;
  import rot_pkg::*;

  localparam int TOTAL  = 17;
  localparam int N_RUN  = 4800;
  localparam int H_TOT  = 120;
  localparam int V_TOT  = 20;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rot_pixel_fetch_if #(.ADDR_W(16), .PIX_W(8)) bus();

  rot_pixel_fetch dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // BRAM model: two-cycle registered read, contents derived from both address bytes
  logic [7:0] ram_q1, ram_q2;

  function automatic logic [7:0] ram_fn(input logic [15:0] a);
    return a[7:0] + a[15:8] + 8'h11;
  endfunction

  always @(posedge clk) begin
    ram_q1 <= ram_fn(bus.mem_addr);
    ram_q2 <= ram_q1;
  end
  assign bus.mem_data = ram_q2;

  typedef struct {
    int          x;
    int          y;
    logic        blank;
    logic [15:0] addr;
    logic [7:0]  pix;
  } vec_t;

  vec_t vecs[13];

  int          xh[N_RUN];
  int          yh[N_RUN];
  logic        bh[N_RUN];
  logic        hh[N_RUN];
  logic        vh[N_RUN];
  logic [31:0] ah[N_RUN];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.x_rot    = '0;
    bus.y_rot    = '0;
    bus.blank    = 1'b1;
    bus.hsync    = 1'b1;
    bus.vsync    = 1'b1;
    bus.hcount   = '0;
    bus.vcount   = '0;
    bus.angle_in = '0;
  endtask

  task automatic apply_stimulus(input int x, input int y, input logic blk);
    bus.x_rot = 12'(x);
    bus.y_rot = 11'(y);
    bus.blank = blk;
  endtask

  function automatic int rand_coord(input int base, input int half);
    case ($urandom_range(0, 3))
      0, 1:    return base - 10 + int'($urandom_range(0, 275));
      2:       return int'($urandom_range(0, 2 * half - 1)) - half;
      default: begin
        case ($urandom_range(0, 3))
          0:       return base - 1;
          1:       return base;
          2:       return base + 255;
          default: return base + 256;
        endcase
      end
    endcase
  endfunction

  // Reference: sprite hit test and address straight from the screen-space rules
  function automatic logic model_hit(input int c, output logic [15:0] a);
    int dxm, dym;
    dxm = (c < 0) ? -272 : xh[c] - 272;
    dym = (c < 0) ? -172 : yh[c] - 172;
    a   = 16'(dym * 256 + dxm);
    return (dxm >= 0) && (dxm < 256) && (dym >= 0) && (dym < 256);
  endfunction

  function automatic logic hist_vs(input int c);
    return (c < 0) ? 1'b1 : vh[c];
  endfunction

  initial begin
    logic [15:0] a;
    logic [15:0] exp_addr;
    logic [31:0] exp_ang;
    logic [7:0]  exp_pix;
    logic        blk;

    vecs[0]  = '{272,  172,  1'b0, 16'h0000, 8'h11};
    vecs[1]  = '{527,  427,  1'b0, 16'hFFFF, 8'h0F};
    vecs[2]  = '{528,  427,  1'b0, 16'hFFFF, 8'h00};
    vecs[3]  = '{527,  -1,   1'b0, 16'hFFFF, 8'h00};
    vecs[4]  = '{300,  200,  1'b0, 16'h1C1C, 8'h49};
    vecs[5]  = '{400,  300,  1'b1, 16'h8080, 8'h00};
    vecs[6]  = '{271,  300,  1'b0, 16'h8080, 8'h00};
    vecs[7]  = '{527,  172,  1'b0, 16'h00FF, 8'h10};
    vecs[8]  = '{272,  427,  1'b0, 16'hFF00, 8'h10};
    vecs[9]  = '{2047, 172,  1'b0, 16'hFF00, 8'h00};
    vecs[10] = '{-2048, 300, 1'b0, 16'hFF00, 8'h00};
    vecs[11] = '{350,  240,  1'b0, 16'h444E, 8'hA3};
    vecs[12] = '{300,  428,  1'b0, 16'h444E, 8'h00};

    drive_idle();
    repeat (3) tick();
    check_output("reset pixel", bus.pixel, 8'h00);
    check_output("reset blank_out", bus.blank_out, 1'b1);
    check_output("reset angle_out", bus.angle_out, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].x, vecs[i].y, vecs[i].blank);
      repeat (20) tick();
      check_output($sformatf("vec%0d mem_addr", i), bus.mem_addr, vecs[i].addr);
      check_output($sformatf("vec%0d pixel", i), bus.pixel, vecs[i].pix);
      check_output($sformatf("vec%0d blank_out", i), bus.blank_out, vecs[i].blank);
    end

    // Blank release must reach blank_out and pixel exactly TOTAL cycles later
    apply_stimulus(272, 172, 1'b1);
    repeat (20) tick();
    apply_stimulus(272, 172, 1'b0);
    for (int k = 1; k <= TOTAL; k++) begin
      tick();
      check_output($sformatf("latency blank_out k=%0d", k), bus.blank_out, (k < TOTAL) ? 1'b1 : 1'b0);
      check_output($sformatf("latency pixel k=%0d", k), bus.pixel, (k < TOTAL) ? 8'h00 : 8'h11);
    end
    check_output("latency mem_addr", bus.mem_addr, 16'h0000);

    bus.angle_in = ANG_45;
    repeat (3) tick();
    check_output("angle before fall", bus.angle_out, 32'h0);
    bus.vsync = 1'b0;
    tick();
    check_output("angle at fall", bus.angle_out, ANG_45);
    bus.angle_in = ANG_90;
    repeat (3) tick();
    check_output("angle held low", bus.angle_out, ANG_45);
    bus.vsync = 1'b1;
    repeat (2) tick();
    check_output("angle held high", bus.angle_out, ANG_45);
    bus.vsync = 1'b0;
    tick();
    check_output("angle next fall", bus.angle_out, ANG_90);
    bus.vsync = 1'b1;

    apply_stimulus(350, 240, 1'b0);
    bus.hsync = 1'b0;
    repeat (20) tick();
    check_output("pre-reset pixel", bus.pixel, 8'hA3);
    check_output("pre-reset hsync_out", bus.hsync_out, 1'b0);
    reset = 1'b0;
    #1;
    check_output("midreset pixel", bus.pixel, 8'h00);
    check_output("midreset hsync_out", bus.hsync_out, 1'b1);
    check_output("midreset vsync_out", bus.vsync_out, 1'b1);
    check_output("midreset blank_out", bus.blank_out, 1'b1);
    check_output("midreset angle_out", bus.angle_out, 32'h0);
    check_output("midreset mem_addr", bus.mem_addr, 16'h0000);
    drive_idle();
    repeat (2) tick();
    reset = 1'b1;

    exp_addr = '0;
    exp_ang  = '0;
    for (int c = 0; c < N_RUN; c++) begin
      int h, v;
      tick();
      if (c >= 2 && model_hit(c - 2, a)) exp_addr = a;
      if (c >= 1 && !hist_vs(c - 1) && hist_vs(c - 2)) exp_ang = ah[c-1];
      blk = (c >= TOTAL) ? bh[c-TOTAL] : 1'b1;
      if (blk)                      exp_pix = 8'h00;
      else if (model_hit(c - 5, a)) exp_pix = ram_fn(a);
      else                          exp_pix = 8'h00;
      check_output($sformatf("run pixel c=%0d", c), bus.pixel, exp_pix);
      check_output($sformatf("run mem_addr c=%0d", c), bus.mem_addr, exp_addr);
      check_output($sformatf("run angle c=%0d", c), bus.angle_out, exp_ang);
      check_output($sformatf("run blank_out c=%0d", c), bus.blank_out, blk);
      check_output($sformatf("run hsync_out c=%0d", c), bus.hsync_out, (c >= TOTAL) ? hh[c-TOTAL] : 1'b1);
      check_output($sformatf("run vsync_out c=%0d", c), bus.vsync_out, (c >= TOTAL) ? vh[c-TOTAL] : 1'b1);

      h     = c % H_TOT;
      v     = (c / H_TOT) % V_TOT;
      xh[c] = rand_coord(272, 2048);
      yh[c] = rand_coord(172, 1024);
      hh[c] = !(h >= 100 && h < 110);
      vh[c] = !(v >= 16 && v < 18);
      bh[c] = (h >= 96) || (v >= 15);
      ah[c] = $urandom;
      bus.hcount   = 11'(h);
      bus.vcount   = 10'(v);
      bus.hsync    = hh[c];
      bus.vsync    = vh[c];
      bus.angle_in = ah[c];
      apply_stimulus(xh[c], yh[c], bh[c]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
